// File: rtl/conv_window_sequencer_if.sv
// Pixel-in / column-out stream bundle for the 3x3 window sequencer.
// slave: sequencer side; master: pixel source and column sink.
interface conv_window_sequencer_if #(
  parameter int unsigned PIXEL_NB = 7
);
  logic [PIXEL_NB-1:0] s00_axis_tdata;
  logic                s00_axis_tvalid;
  logic                s00_axis_tready;
  logic                s00_axis_tlast;
  logic [PIXEL_NB-1:0] o_col_top;
  logic [PIXEL_NB-1:0] o_col_mid;
  logic [PIXEL_NB-1:0] o_col_bot;
  logic                o_col_valid;
  logic                i_col_ready;
  logic                o_row_first;
  logic                o_win_valid;
  logic                o_win_last;

  modport slave (
    input  s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast, i_col_ready,
    output s00_axis_tready, o_col_top, o_col_mid, o_col_bot, o_col_valid,
           o_row_first, o_win_valid, o_win_last
  );

  modport master (
    output s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast, i_col_ready,
    input  s00_axis_tready, o_col_top, o_col_mid, o_col_bot, o_col_valid,
           o_row_first, o_win_valid, o_win_last
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Raster-to-window scheduler: buffers two image rows and emits one vertical
// 3-pixel column per accepted pixel from row 2 onward, with window/frame flags.
module conv_window_sequencer #(
  parameter int unsigned PIXEL_NB  = 7,
  parameter int unsigned DIM_NB    = 10,
  parameter int unsigned MAX_WIDTH = 640
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DIM_NB-1:0]     i_cfg_width,
  input  logic [DIM_NB-1:0]     i_cfg_height,
  conv_window_sequencer_if.slave io_bus,
  output logic                  o_frame_done,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned LbAw = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [DIM_NB-1:0]   r_w_m1;
  logic [DIM_NB-1:0]   r_h_m1;
  logic [DIM_NB-1:0]   r_row;
  logic [DIM_NB-1:0]   r_col;
  logic                r_err;
  logic                r_col_valid;
  logic                r_row_first;
  logic                r_win_valid;
  logic                r_win_last;
  logic [PIXEL_NB-1:0] r_top;
  logic [PIXEL_NB-1:0] r_mid;
  logic [PIXEL_NB-1:0] r_bot;
  logic [PIXEL_NB-1:0] r_lb0 [MAX_WIDTH];
  logic [PIXEL_NB-1:0] r_lb1 [MAX_WIDTH];

  logic                w_tready;
  logic                w_accept;
  logic                w_last_col;
  logic                w_last_row;
  logic                w_final;
  logic                w_cfg_bad;
  logic                w_start_ok;
  logic [LbAw-1:0]     w_idx;

  assign w_tready   = ((r_state == StPrime) || (r_state == StRun)) && !i_abort &&
                      (!r_col_valid || io_bus.i_col_ready);
  assign w_accept   = io_bus.s00_axis_tvalid && w_tready;
  assign w_last_col = (r_col == r_w_m1);
  assign w_last_row = (r_row == r_h_m1);
  assign w_final    = w_last_col && w_last_row;
  assign w_cfg_bad  = (i_cfg_width < DIM_NB'(3)) || (i_cfg_height < DIM_NB'(3)) ||
                      (32'(i_cfg_width) > MAX_WIDTH);
  assign w_start_ok = i_start && !i_abort && (r_state == StIdle);
  assign w_idx      = r_col[LbAw-1:0];

  always_comb begin
    w_state_next = r_state;
    if (i_abort) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (i_start && !w_cfg_bad) w_state_next = StPrime;
        StPrime: if (w_accept && w_last_col && (r_row == DIM_NB'(1))) w_state_next = StRun;
        StRun:   if (w_accept && w_final) w_state_next = StDone;
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_w_m1      <= '0;
      r_h_m1      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_err       <= 1'b0;
      r_col_valid <= 1'b0;
      r_row_first <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_top       <= '0;
      r_mid       <= '0;
      r_bot       <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_abort) begin
        r_row       <= '0;
        r_col       <= '0;
        r_col_valid <= 1'b0;
        r_row_first <= 1'b0;
        r_win_valid <= 1'b0;
        r_win_last  <= 1'b0;
      end else begin
        if (w_start_ok) begin
          r_w_m1 <= i_cfg_width - DIM_NB'(1);
          r_h_m1 <= i_cfg_height - DIM_NB'(1);
          r_err  <= w_cfg_bad;
          r_row  <= '0;
          r_col  <= '0;
        end
        if (w_accept) begin
          if (w_last_col) begin
            r_col <= '0;
            r_row <= r_row + DIM_NB'(1);
          end else begin
            r_col <= r_col + DIM_NB'(1);
          end
          // tlast is only checked; sequencing follows the latched dimensions
          if (io_bus.s00_axis_tlast != w_final) r_err <= 1'b1;
        end
        if (w_accept && (r_state == StRun)) begin
          r_top       <= r_lb1[w_idx];
          r_mid       <= r_lb0[w_idx];
          r_bot       <= io_bus.s00_axis_tdata;
          r_col_valid <= 1'b1;
          r_row_first <= (r_col == '0);
          r_win_valid <= (r_col >= DIM_NB'(2));
          r_win_last  <= w_final;
        end else if (io_bus.i_col_ready) begin
          r_col_valid <= 1'b0;
          r_row_first <= 1'b0;
          r_win_valid <= 1'b0;
          r_win_last  <= 1'b0;
        end
      end
    end
  end

  // Line buffers shift down one row per accepted pixel; contents need no reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_lb1[w_idx] <= r_lb0[w_idx];
      r_lb0[w_idx] <= io_bus.s00_axis_tdata;
    end
  end

  assign io_bus.s00_axis_tready = w_tready;
  assign io_bus.o_col_top       = r_top;
  assign io_bus.o_col_mid       = r_mid;
  assign io_bus.o_col_bot       = r_bot;
  assign io_bus.o_col_valid     = r_col_valid;
  assign io_bus.o_row_first     = r_row_first;
  assign io_bus.o_win_valid     = r_win_valid;
  assign io_bus.o_win_last      = r_win_last;
  assign o_frame_done           = (r_state == StDone) && !i_abort;
  assign o_busy                 = (r_state != StIdle);
  assign o_err                  = r_err;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench: the driver queues expected columns per accepted pixel,
// a negedge monitor pops and compares on every column handshake.
module tb_conv_window_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       i_start;
  logic       i_abort;
  logic [9:0] i_cfg_width;
  logic [9:0] i_cfg_height;
  logic       o_frame_done;
  logic       o_busy;
  logic       o_err;

  conv_window_sequencer_if #(.PIXEL_NB(7)) cw_if ();

  conv_window_sequencer #(.PIXEL_NB(7), .DIM_NB(10), .MAX_WIDTH(640)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_cfg_width  (i_cfg_width),
    .i_cfg_height (i_cfg_height),
    .io_bus       (cw_if),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0] top;
    logic [6:0] mid;
    logic [6:0] bot;
    logic       first;
    logic       win;
    logic       last;
  } col_t;

  col_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   fd_cnt = 0;
  int   win_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each transferred column against the scoreboard head
  always @(negedge clock) begin
    if (o_frame_done) fd_cnt++;
    if (cw_if.o_col_valid && cw_if.i_col_ready) begin
      if (cw_if.o_win_valid) win_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_column", {25'd0, cw_if.o_col_bot}, 32'hFFFF_FFFF);
      end else begin
        col_t e;
        e = q.pop_front();
        chk("column", {11'd0, cw_if.o_col_top, cw_if.o_col_mid, cw_if.o_col_bot,
                       cw_if.o_row_first, cw_if.o_win_valid, cw_if.o_win_last},
            {11'd0, e});
      end
    end
  end

  task automatic do_start(input int w, input int h);
    @(posedge clock); #1;
    i_cfg_width  = 10'(w);
    i_cfg_height = 10'(h);
    i_start      = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
  endtask

  // stop_mode: 0 full frame, 1 abort after stop_at accepts, 2 reset after stop_at
  // rdy_mode: 0 ready high, 1 ready toggling, 2 ready low
  task automatic run_frame(input int w, input int h, input int tl_idx, input int stop_at,
                           input int stop_mode, input int rdy_mode, input int exp_err);
    int total;
    int lim;
    int i;
    int cyc;
    total   = w * h;
    lim     = (stop_mode != 0) ? stop_at : total;
    i       = 0;
    cyc     = 0;
    fd_cnt  = 0;
    win_cnt = 0;
    cw_if.i_col_ready = (rdy_mode == 2) ? 1'b0 : 1'b1;
    do_start(w, h);
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    chk("err_after_start", {31'd0, o_err}, 32'd0);
    cw_if.s00_axis_tvalid = 1'b1;
    cw_if.s00_axis_tdata  = 7'd0;
    cw_if.s00_axis_tlast  = (tl_idx == 0);
    while (i < lim && cyc < 2000) begin
      @(negedge clock);
      if (rdy_mode == 1 && cw_if.o_col_valid && !cw_if.i_col_ready)
        chk("stall_tready", {31'd0, cw_if.s00_axis_tready}, 32'd0);
      if (cw_if.s00_axis_tready) begin
        if (i / w >= 2) begin
          col_t e;
          e.top   = 7'(i - 2 * w);
          e.mid   = 7'(i - w);
          e.bot   = 7'(i);
          e.first = (i % w == 0);
          e.win   = (i % w >= 2);
          e.last  = (i == total - 1);
          q.push_back(e);
        end
        i++;
      end
      @(posedge clock); #1;
      cw_if.s00_axis_tdata = 7'(i);
      cw_if.s00_axis_tlast = (i == tl_idx);
      if (rdy_mode == 1) cw_if.i_col_ready = ~cw_if.i_col_ready;
      cyc++;
    end
    if (cyc >= 2000) chk("feed_timeout", 32'(i), 32'(lim));

    if (stop_mode == 0) begin
      int k;
      cw_if.s00_axis_tvalid = 1'b0;
      cw_if.s00_axis_tlast  = 1'b0;
      cw_if.i_col_ready     = 1'b1;
      for (k = 0; k < 50; k++) begin
        @(negedge clock);
        if (!o_busy && !cw_if.o_col_valid) break;
      end
      chk("drain_timeout", 32'(k < 50), 32'd1);
      chk("queue_empty", 32'(q.size()), 32'd0);
      chk("frame_done_count", 32'(fd_cnt), 32'd1);
      chk("win_count", 32'(win_cnt), 32'((h - 2) * (w - 2)));
      chk("err_end", {31'd0, o_err}, 32'(exp_err));
    end else if (stop_mode == 1) begin
      i_abort = 1'b1;
      @(negedge clock);
      chk("abort_tready", {31'd0, cw_if.s00_axis_tready}, 32'd0);
      @(posedge clock); #1;
      i_abort = 1'b0;
      cw_if.s00_axis_tvalid = 1'b0;
      @(negedge clock);
      chk("abort_col_valid", {31'd0, cw_if.o_col_valid}, 32'd0);
      chk("abort_busy", {31'd0, o_busy}, 32'd0);
      chk("abort_no_done", 32'(fd_cnt), 32'd0);
      chk("abort_queue", 32'(q.size()), 32'd0);
    end else begin
      @(negedge clock);
      chk("stalled_valid", {31'd0, cw_if.o_col_valid}, 32'd1);
      chk("stalled_tready", {31'd0, cw_if.s00_axis_tready}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("rst_outputs", {24'd0, cw_if.s00_axis_tready, cw_if.o_col_valid, cw_if.o_row_first,
                          cw_if.o_win_valid, cw_if.o_win_last, o_frame_done, o_busy, o_err},
          32'd0);
      chk("rst_col_data", {11'd0, cw_if.o_col_top, cw_if.o_col_mid, cw_if.o_col_bot}, 32'd0);
      reset = 1'b0;
      cw_if.s00_axis_tvalid = 1'b0;
      cw_if.i_col_ready     = 1'b1;
      q.delete();
    end
  endtask

  initial begin
    reset                 = 1'b1;
    i_start               = 1'b0;
    i_abort               = 1'b0;
    i_cfg_width           = '0;
    i_cfg_height          = '0;
    cw_if.s00_axis_tdata  = '0;
    cw_if.s00_axis_tvalid = 1'b0;
    cw_if.s00_axis_tlast  = 1'b0;
    cw_if.i_col_ready     = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state", {27'd0, cw_if.s00_axis_tready, cw_if.o_col_valid, o_frame_done,
                        o_busy, o_err}, 32'd0);
    reset = 1'b0;

    // Nominal 5x4 frame
    run_frame(5, 4, 19, 0, 0, 0, 0);
    // Same frame with back-pressure toggling every cycle
    run_frame(5, 4, 19, 0, 0, 1, 0);

    // Rejected configuration
    do_start(2, 8);
    @(negedge clock);
    chk("bad_cfg_err", {31'd0, o_err}, 32'd1);
    chk("bad_cfg_busy", {31'd0, o_busy}, 32'd0);
    cw_if.s00_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("bad_cfg_tready", {31'd0, cw_if.s00_axis_tready}, 32'd0);
    end
    cw_if.s00_axis_tvalid = 1'b0;
    run_frame(3, 3, 8, 0, 0, 0, 0);

    // Early tlast on pixel 5 (and thus missing on the final pixel)
    run_frame(4, 3, 5, 0, 0, 0, 1);

    // Abort after 12 accepts, then an identical clean frame
    run_frame(5, 4, 19, 12, 1, 0, 0);
    run_frame(5, 4, 19, 0, 0, 0, 0);

    // Reset while a column is stalled in RUN
    run_frame(5, 4, 19, 11, 2, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
